// File: rtl/winograd_pkg.sv
// Shared types and geometry helpers for the Winograd tile scheduler.
// Kept free of module state so any block can import it.
package winograd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DONE,
        NEXT,
        DONE
    } state_t;

    function automatic int stride(input int tile_size, input int kernel_size);
        return tile_size - kernel_size + 1;
    endfunction

    function automatic int tiles_per_dim(input int dim, input int tile_size, input int s);
        return (dim - tile_size) / s + 1;
    endfunction

    // Counters for a single-value range still need one bit to exist.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/winograd_tile_scheduler_if.sv
// Bus bundle between the tile scheduler, its frame buffer and the Winograd datapath.
// The master modport is the scheduler's view; slave is the environment's view.
interface winograd_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ROW_WIDTH  = 2,
    parameter int COL_WIDTH  = 2
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] o_pixel_data;
    logic                  o_pixel_data_valid;
    logic [ROW_WIDTH-1:0]  o_tile_row;
    logic [COL_WIDTH-1:0]  o_tile_col;
    logic                  i_tile_done;

    modport master (
        input  start, rd_data, i_tile_done,
        output busy, done, rd_en, rd_addr,
        output o_pixel_data, o_pixel_data_valid, o_tile_row, o_tile_col
    );

    modport slave (
        output start, rd_data, i_tile_done,
        input  busy, done, rd_en, rd_addr,
        input  o_pixel_data, o_pixel_data_valid, o_tile_row, o_tile_col
    );
endinterface

// File: rtl/tile_addr_gen.sv
// Channel/row/column walker for one tile; produces the frame buffer address by
// adding constant jumps to registered bases, so the fetch path holds no multiplier.
module tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int TILE_SIZE    = 4,
    parameter int CHANNELS     = 3,
    parameter int STRIDE       = 2,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  step,
    input  logic                  tile_advance,
    input  logic                  row_wrap,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam int K_W = clog2_min1(TILE_SIZE);
    localparam int C_W = clog2_min1(CHANNELS);

    // Jumps applied at the end of a tile line, at the end of a channel plane,
    // and when moving the tile origin sideways or down one tile row.
    localparam logic [ADDR_WIDTH-1:0] ROW_JUMP  = ADDR_WIDTH'(IMAGE_WIDTH - TILE_SIZE + 1);
    localparam logic [ADDR_WIDTH-1:0] CHAN_JUMP = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT
                                                  - (TILE_SIZE - 1) * IMAGE_WIDTH
                                                  - (TILE_SIZE - 1));
    localparam logic [ADDR_WIDTH-1:0] COL_STEP  = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(STRIDE * IMAGE_WIDTH);

    logic [K_W-1:0]        k_q;
    logic [K_W-1:0]        r_q;
    logic [C_W-1:0]        c_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] tile_base_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [ADDR_WIDTH-1:0] next_row_base;
    logic [ADDR_WIDTH-1:0] next_tile_base;
    logic                  k_last;
    logic                  r_last;
    logic                  c_last;

    assign k_last = (k_q == K_W'(TILE_SIZE - 1));
    assign r_last = (r_q == K_W'(TILE_SIZE - 1));
    assign c_last = (c_q == C_W'(CHANNELS - 1));
    assign last   = k_last && r_last && c_last;
    assign addr   = addr_q;

    assign next_row_base  = row_wrap ? row_base_q + ROW_STEP : row_base_q;
    assign next_tile_base = row_wrap ? row_base_q + ROW_STEP : tile_base_q + COL_STEP;

    // NOTE: state registers use non-blocking assignments so every register in
    // this clock domain samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset || frame_start) begin
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            tile_base_q <= '0;
            row_base_q  <= '0;
        end else if (tile_advance) begin
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            row_base_q  <= next_row_base;
            tile_base_q <= next_tile_base;
            addr_q      <= next_tile_base;
        end else if (step) begin
            if (!k_last) begin
                k_q    <= k_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end else if (!r_last) begin
                k_q    <= '0;
                r_q    <= r_q + 1'b1;
                addr_q <= addr_q + ROW_JUMP;
            end else if (!c_last) begin
                k_q    <= '0;
                r_q    <= '0;
                c_q    <= c_q + 1'b1;
                addr_q <= addr_q + CHAN_JUMP;
            end else begin
                // Tile finished: park on the origin so a re-walk would repeat it.
                k_q    <= '0;
                r_q    <= '0;
                c_q    <= '0;
                addr_q <= tile_base_q;
            end
        end
    end
endmodule

// File: rtl/winograd_tile_scheduler.sv
// Walks overlapping tiles of a channel-planar frame, streaming each tile as one
// contiguous pixel burst and waiting for the datapath's tile_done between tiles.
module winograd_tile_scheduler
    import winograd_pkg::*;
#(
    parameter int KERNEL_SIZE        = 3,
    parameter int INPUT_IMAGE_WIDTH  = 10,
    parameter int INPUT_IMAGE_HEIGHT = 10,
    parameter int INPUT_TILE_SIZE    = 4,
    parameter int INPUT_DATA_WIDTH   = 8,
    parameter int CHANNELS           = 3
) (
    input logic                        clk,
    input logic                        reset,
    winograd_tile_scheduler_if.master  bus
);
    localparam int S          = stride(INPUT_TILE_SIZE, KERNEL_SIZE);
    localparam int TX         = tiles_per_dim(INPUT_IMAGE_WIDTH, INPUT_TILE_SIZE, S);
    localparam int TY         = tiles_per_dim(INPUT_IMAGE_HEIGHT, INPUT_TILE_SIZE, S);
    localparam int ADDR_WIDTH = $clog2(CHANNELS * INPUT_IMAGE_WIDTH * INPUT_IMAGE_HEIGHT);
    localparam int COL_W      = clog2_min1(TX);
    localparam int ROW_W      = clog2_min1(TY);

    if (((INPUT_IMAGE_WIDTH - INPUT_TILE_SIZE) % S != 0) ||
        ((INPUT_IMAGE_HEIGHT - INPUT_TILE_SIZE) % S != 0)) begin : g_bad_geometry
        $error("winograd_tile_scheduler: image dimensions do not tile with stride %0d", S);
    end

    state_t                state_q;
    state_t                state_d;
    logic [COL_W-1:0]      tx_q;
    logic [ROW_W-1:0]      ty_q;
    logic                  valid_q;
    logic                  rd_en;
    logic                  step;
    logic                  frame_start;
    logic                  tile_advance;
    logic                  row_wrap;
    logic                  frame_last;
    logic                  addr_last;
    logic [ADDR_WIDTH-1:0] addr;

    tile_addr_gen #(
        .IMAGE_WIDTH  (INPUT_IMAGE_WIDTH),
        .IMAGE_HEIGHT (INPUT_IMAGE_HEIGHT),
        .TILE_SIZE    (INPUT_TILE_SIZE),
        .CHANNELS     (CHANNELS),
        .STRIDE       (S),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .step         (step),
        .tile_advance (tile_advance),
        .row_wrap     (row_wrap),
        .addr         (addr),
        .last         (addr_last)
    );

    assign row_wrap   = (tx_q == COL_W'(TX - 1));
    assign frame_last = row_wrap && (ty_q == ROW_W'(TY - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= rd_en;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        step         = 1'b0;
        frame_start  = 1'b0;
        tile_advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    frame_start = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                step  = 1'b1;
                if (addr_last) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A tile_done arriving while the last pixel is still in flight is dropped.
                if (bus.i_tile_done && !valid_q) state_d = NEXT;
            end
            NEXT: begin
                if (frame_last) begin
                    state_d = DONE;
                end else begin
                    tile_advance = 1'b1;
                    state_d      = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || frame_start) begin
            tx_q <= '0;
            ty_q <= '0;
        end else if (tile_advance) begin
            if (row_wrap) begin
                tx_q <= '0;
                ty_q <= ty_q + 1'b1;
            end else begin
                tx_q <= tx_q + 1'b1;
            end
        end
    end

    assign bus.rd_en              = rd_en;
    assign bus.rd_addr            = addr;
    assign bus.busy               = (state_q == FETCH) || (state_q == WAIT_DONE) || (state_q == NEXT);
    assign bus.done               = (state_q == DONE);
    assign bus.o_pixel_data_valid = valid_q;
    assign bus.o_pixel_data       = valid_q ? bus.rd_data : {INPUT_DATA_WIDTH{1'b0}};
    assign bus.o_tile_row         = ty_q;
    assign bus.o_tile_col         = tx_q;
endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Directed bench for winograd_tile_scheduler on a 10x10x3 frame with 4x4 tiles, stride 2;
// the frame buffer model returns the low byte of the address one cycle after rd_en.
module tb_winograd_tile_scheduler;
    localparam int K   = 3;
    localparam int W   = 10;
    localparam int H   = 10;
    localparam int T   = 4;
    localparam int DW  = 8;
    localparam int C   = 3;
    localparam int S   = 2;
    localparam int NT  = 4;
    localparam int PIX = C * T * T;
    localparam int AW  = 9;
    localparam int IW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    winograd_tile_scheduler_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROW_WIDTH  (IW),
        .COL_WIDTH  (IW)
    ) bus ();

    winograd_tile_scheduler #(
        .KERNEL_SIZE        (K),
        .INPUT_IMAGE_WIDTH  (W),
        .INPUT_IMAGE_HEIGHT (H),
        .INPUT_TILE_SIZE    (T),
        .INPUT_DATA_WIDTH   (DW),
        .CHANNELS           (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
    end

    function automatic logic [AW-1:0] exp_addr(input int ty, input int tx, input int i);
        int c = i / (T * T);
        int r = (i / T) % T;
        int k = i % T;
        return AW'(c * W * H + (ty * S + r) * W + tx * S + k);
    endfunction

    // Streams one tile starting from a FETCH (or the cycle just before it) and retires it.
    task automatic run_tile(input int ty, input int tx, input bit noise, input bit early_done);
        int            waited = 0;
        logic [AW-1:0] ea;
        logic [AW-1:0] pa;
        while (bus.rd_en !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_start tile(%0d,%0d): rd_en=%b after 10 cycles, expected 1", ty, tx, bus.rd_en);
            return;
        end
        for (int i = 0; i < PIX; i++) begin
            ea = exp_addr(ty, tx, i);
            vectors++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== ea ||
                bus.o_tile_row !== IW'(ty) || bus.o_tile_col !== IW'(tx)) begin
                miscompares++;
                $display("FAIL fetch tile(%0d,%0d) i=%0d: rd_en=%b addr=%0d row=%0d col=%0d, expected 1 %0d %0d %0d",
                         ty, tx, i, bus.rd_en, bus.rd_addr, bus.o_tile_row, bus.o_tile_col, ea, ty, tx);
            end
            vectors++;
            if (i == 0) begin
                if (bus.o_pixel_data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL first_valid tile(%0d,%0d): valid=%b, expected 0", ty, tx, bus.o_pixel_data_valid);
                end
            end else begin
                pa = exp_addr(ty, tx, i - 1);
                if (bus.o_pixel_data_valid !== 1'b1 || bus.o_pixel_data !== pa[7:0]) begin
                    miscompares++;
                    $display("FAIL pixel tile(%0d,%0d) i=%0d: valid=%b data=%0d, expected 1 %0d",
                             ty, tx, i - 1, bus.o_pixel_data_valid, bus.o_pixel_data, pa[7:0]);
                end
            end
            if (noise) begin
                if (i == 10) bus.i_tile_done = 1'b1;
                if (i == 11) bus.i_tile_done = 1'b0;
                if (i == 20) bus.start = 1'b1;
                if (i == 21) bus.start = 1'b0;
            end
            @(negedge clk);
        end
        pa = exp_addr(ty, tx, PIX - 1);
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.o_pixel_data_valid !== 1'b1 || bus.o_pixel_data !== pa[7:0] ||
            bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL last_pixel tile(%0d,%0d): rd_en=%b valid=%b data=%0d busy=%b, expected 0 1 %0d 1",
                     ty, tx, bus.rd_en, bus.o_pixel_data_valid, bus.o_pixel_data, bus.busy, pa[7:0]);
        end
        if (early_done) bus.i_tile_done = 1'b1;
        @(negedge clk);
        bus.i_tile_done = 1'b0;
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.o_pixel_data_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
            bus.o_tile_row !== IW'(ty) || bus.o_tile_col !== IW'(tx)) begin
            miscompares++;
            $display("FAIL wait_done tile(%0d,%0d): rd_en=%b valid=%b busy=%b done=%b row=%0d col=%0d, expected 0 0 1 0 %0d %0d",
                     ty, tx, bus.rd_en, bus.o_pixel_data_valid, bus.busy, bus.done,
                     bus.o_tile_row, bus.o_tile_col, ty, tx);
        end
        if (early_done) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                vectors++;
                if (bus.rd_en !== 1'b0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lost_tile_done tile(%0d,%0d) cycle %0d: rd_en=%b busy=%b, expected 0 1",
                             ty, tx, j, bus.rd_en, bus.busy);
                end
            end
        end
        bus.i_tile_done = 1'b1;
        @(negedge clk);
        bus.i_tile_done = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.i_tile_done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.o_pixel_data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rd_addr !== '0 || bus.o_tile_row !== '0 || bus.o_tile_col !== '0 || bus.o_pixel_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rd_en=%b valid=%b busy=%b done=%b addr=%0d row=%0d col=%0d data=%0d, expected all 0",
                     bus.rd_en, bus.o_pixel_data_valid, bus.busy, bus.done, bus.rd_addr,
                     bus.o_tile_row, bus.o_tile_col, bus.o_pixel_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_tile();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.rd_en !== 1'b1 || bus.busy !== 1'b1 || bus.rd_addr !== '0) begin
            miscompares++;
            $display("FAIL start_latency: rd_en=%b busy=%b addr=%0d, expected 1 1 0", bus.rd_en, bus.busy, bus.rd_addr);
        end
        // tile_done and start injected mid-burst, plus a tile_done lost to the pending last pixel.
        run_tile(0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_frame();
        for (int ty = 0; ty < NT; ty++) begin
            for (int tx = 0; tx < NT; tx++) begin
                if (ty != 0 || tx != 0) run_tile(ty, tx, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_done();
        int seen = 0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_done: busy=%b done=%b, expected 1 0", bus.busy, bus.done);
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen++;
                vectors++;
                if (bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_at_done: busy=%b, expected 0", bus.busy);
                end
                bus.start = 1'b1;
            end
            vectors++;
            if (bus.rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL start_at_done cycle %0d: rd_en=%b, expected 0", t, bus.rd_en);
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (seen != 1) begin
            miscompares++;
            $display("FAIL done_pulses: got %0d, expected 1", seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] ea;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        ea = exp_addr(0, 0, 20);
        vectors++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== ea) begin
            miscompares++;
            $display("FAIL pixel20: rd_en=%b addr=%0d, expected 1 %0d", bus.rd_en, bus.rd_addr, ea);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.o_pixel_data_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rd_addr !== '0 || bus.o_pixel_data !== '0) begin
            miscompares++;
            $display("FAIL abort: rd_en=%b valid=%b busy=%b addr=%0d data=%0d, expected all 0",
                     bus.rd_en, bus.o_pixel_data_valid, bus.busy, bus.rd_addr, bus.o_pixel_data);
        end
        @(negedge clk);
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.o_pixel_data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_abort_idle: rd_en=%b valid=%b, expected 0 0", bus.rd_en, bus.o_pixel_data_valid);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_tile(0, 0, 1'b0, 1'b0);
        run_tile(0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_tile();
        test_frame();
        test_done();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
